sd_data_serial_engine: RTL and testbench
========================================

SD_DATA_SERIAL_ENGINE -- requirements
Module: sd_data_serial_engine

Interface
REQ-001 Parameter NWR, default 2: sd_clk cycles between write end bit and CRC-status token start-bit window; range 2..8.
REQ-002 sd_clk  in  1  sole clock; all state changes on rising edge.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 start_write_i  in  1  one-cycle pulse from data master; begin block write to card.
REQ-005 start_read_i  in  1  one-cycle pulse from data master; begin block read from card.
REQ-006 blksize_i  in  12  bytes per block; multiple of 4, 4..2048; sampled on start.
REQ-007 blkcnt_i  in  16  blocks per transfer; 0 treated as 1; sampled on start.
REQ-008 tx_data_i  in  32  head word of tx FIFO (first-word-fall-through).
REQ-009 tx_rd_o  out  1  pop strobe for tx FIFO.
REQ-010 rx_data_o  out  32  received word.
REQ-011 rx_we_o  out  1  push strobe for rx FIFO; rx_data_o valid same cycle.
REQ-012 sd_dat_i  in  1  DAT0 from card, pre-synchronised.
REQ-013 sd_dat_o  out  1  DAT0 to card.
REQ-014 sd_dat_oe_o  out  1  DAT0 output enable.
REQ-015 xfr_complete_o  out  1  1 = idle; 0 = transfer in progress.
REQ-016 crc_ok_o  out  1  transfer CRC result; valid while xfr_complete_o=1, held until next start.

Function
REQ-017 States: IDLE, WR_PRE, WR_START, WR_DATA, WR_CRC, WR_END, WR_GAP, WR_TOKEN, WR_BUSY, RD_WAIT, RD_DATA, RD_CRC, RD_END.
REQ-018 Start pulse at cycle T: FSM leaves IDLE at T+1; xfr_complete_o=0 from T+1; crc_ok_o set to 1 at T+1 (accumulating AND).
REQ-019 start_write_i and start_read_i high in same cycle = abort from any state: next cycle IDLE, oe=0, sd_dat_o=1, xfr_complete_o=1, crc_ok_o=0, no further FIFO strobes.
REQ-020 Single start pulse while busy: ignored.
REQ-021 Write: WR_PRE drives 1 for one cycle (oe=1); WR_START drives 0; WR_DATA drives 8*blksize bits MSB-first per word; WR_CRC drives 16 bits MSB-first; WR_END drives 1.
REQ-022 CRC16: polynomial x^16+x^12+x^5+1, init 0x0000, over data bits only, cleared per block.
REQ-023 tx_rd_o pulses in the WR_START cycle and in each cycle driving bit 0 of a word that is not the block's last word; shift register loads tx_data_i on that edge; exactly blksize/4 pulses per block.
REQ-024 After WR_END: oe=0; WR_GAP NWR cycles; WR_TOKEN waits for sd_dat_i=0, then samples 3 status bits and end bit.
REQ-025 Token 010 = accepted; any other value: crc_ok_o=0, go to IDLE without further blocks.
REQ-026 WR_BUSY: wait until sd_dat_i=1 (card busy release), then next block from WR_PRE, or IDLE after last block.
REQ-027 Read: RD_WAIT waits indefinitely for sd_dat_i=0 (timeout owned by data master; abort per REQ-019); RD_DATA shifts 8*blksize bits MSB-first.
REQ-028 rx_we_o pulses one cycle after the 32nd bit of each word is sampled; rx_data_o holds the word until next push.
REQ-029 RD_CRC samples 16 bits; mismatch clears crc_ok_o; RD_END samples end bit; end bit 0 clears crc_ok_o.
REQ-030 After RD_END: next block returns to RD_WAIT; last block goes to IDLE.
REQ-031 Block counter decrements once per completed block; no wrap; transfer ends at count 1.
REQ-032 oe=1 only in WR_PRE..WR_END; otherwise sd_dat_o=1.

Reset
REQ-033 rst high at an edge, any state: next cycle IDLE, sd_dat_oe_o=0, sd_dat_o=1, xfr_complete_o=1, crc_ok_o=0, tx_rd_o=0, rx_we_o=0, rx_data_o=0, counters and CRC cleared.
REQ-034 rst has priority over start and abort.

Verification
REQ-035 Write blksize=512, blkcnt=1, tx_data_i=0xFFFFFFFF, card token 0-010-1, busy 5 cycles -> line: 1,0, 4096 ones, CRC 0x7FA1, 1; 128 tx_rd_o pulses; xfr_complete_o=1, crc_ok_o=1.
REQ-036 Read blksize=512, blkcnt=2, card sends 0, 4096 ones, 0x7FA1, 1 per block -> 256 rx_we_o pulses of 0xFFFFFFFF; crc_ok_o=1.
REQ-037 Read with CRC 0x7FA0 -> 128 pushes, xfr_complete_o=1, crc_ok_o=0.
REQ-038 Write blkcnt=2, first token 0-101-1 -> 128 tx_rd_o pulses only, IDLE, crc_ok_o=0, oe=0.
REQ-039 Read, card silent 50 cycles, then start_write_i=start_read_i=1 -> next cycle xfr_complete_o=1, crc_ok_o=0, no rx_we_o.
REQ-040 rst asserted mid-WR_DATA -> next cycle all outputs per REQ-033; subsequent blksize=4 write completes normally.

Source files
------------

// File: rtl/sd_data_serial_engine.sv
// SD card DAT0 serial engine: single-line block write/read with CRC16,
// write CRC-status token and busy handling, driven by a data-master FSM interface.
module sd_data_serial_engine #(
  parameter int NWR = 2
) (
  input  logic        sd_clk,
  input  logic        rst,
  input  logic        start_write_i,
  input  logic        start_read_i,
  input  logic [11:0] blksize_i,
  input  logic [15:0] blkcnt_i,
  input  logic [31:0] tx_data_i,
  output logic        tx_rd_o,
  output logic [31:0] rx_data_o,
  output logic        rx_we_o,
  input  logic        sd_dat_i,
  output logic        sd_dat_o,
  output logic        sd_dat_oe_o,
  output logic        xfr_complete_o,
  output logic        crc_ok_o
);

  typedef enum logic [3:0] {
    IDLE, WR_PRE, WR_START, WR_DATA, WR_CRC, WR_END, WR_GAP, WR_TOKEN, WR_BUSY,
    RD_WAIT, RD_DATA, RD_CRC, RD_END
  } state_t;

  localparam logic [2:0] GAP_LAST = 3'(NWR - 1);

  state_t      state, state_next;
  logic [11:0] blksize;
  logic [15:0] blk_cnt;
  logic [14:0] bit_cnt;
  logic [31:0] shift;
  logic [15:0] crc;
  logic [2:0]  gap_cnt;
  logic [2:0]  tok_cnt;
  logic [2:0]  tok;
  logic        crc_ok;
  logic [31:0] rx_data;
  logic        rx_we;

  logic        abort, start_wr, start_rd;
  logic        last_data_bit, word_end, crc_last, last_block;
  logic        data_bit;
  logic [15:0] crc_next;
  logic [14:0] total_bits;

  assign abort      = start_write_i & start_read_i;
  assign start_wr   = start_write_i & ~start_read_i;
  assign start_rd   = start_read_i & ~start_write_i;

  assign total_bits    = {blksize, 3'b000};
  assign last_data_bit = (bit_cnt == total_bits - 15'd1);
  assign word_end      = (bit_cnt[4:0] == 5'd31);
  assign crc_last      = (bit_cnt[3:0] == 4'd15);
  assign last_block    = (blk_cnt <= 16'd1);

  // The same CRC update serves both directions; only the source bit differs.
  assign data_bit = (state == RD_DATA) ? sd_dat_i : shift[31];
  assign crc_next = {crc[14:0], 1'b0} ^ ((crc[15] ^ data_bit) ? 16'h1021 : 16'h0000);

  always_ff @(posedge sd_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    sd_dat_o    = 1'b1;
    sd_dat_oe_o = 1'b0;
    tx_rd_o     = 1'b0;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start_wr)      state_next = WR_PRE;
          else if (start_rd) state_next = RD_WAIT;
        end
        WR_PRE:   state_next = WR_START;
        WR_START: state_next = WR_DATA;
        WR_DATA:  if (last_data_bit) state_next = WR_CRC;
        WR_CRC:   if (crc_last) state_next = WR_END;
        WR_END:   state_next = WR_GAP;
        WR_GAP:   if (gap_cnt == GAP_LAST) state_next = WR_TOKEN;
        WR_TOKEN: if (tok_cnt == 3'd4) state_next = (tok == 3'b010) ? WR_BUSY : IDLE;
        WR_BUSY:  if (sd_dat_i) state_next = last_block ? IDLE : WR_PRE;
        RD_WAIT:  if (!sd_dat_i) state_next = RD_DATA;
        RD_DATA:  if (last_data_bit) state_next = RD_CRC;
        RD_CRC:   if (crc_last) state_next = RD_END;
        RD_END:   state_next = last_block ? IDLE : RD_WAIT;
        default:  state_next = IDLE;
      endcase
    end
    case (state)
      WR_PRE:   sd_dat_oe_o = 1'b1;
      WR_START: begin
        sd_dat_oe_o = 1'b1;
        sd_dat_o    = 1'b0;
        tx_rd_o     = ~abort & ~rst;
      end
      WR_DATA: begin
        sd_dat_oe_o = 1'b1;
        sd_dat_o    = shift[31];
        tx_rd_o     = word_end & ~last_data_bit & ~abort & ~rst;
      end
      WR_CRC: begin
        sd_dat_oe_o = 1'b1;
        sd_dat_o    = crc[15];
      end
      WR_END:  sd_dat_oe_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge sd_clk) begin
    if (rst) begin
      blksize <= '0;
      blk_cnt <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      crc     <= '0;
      gap_cnt <= '0;
      tok_cnt <= '0;
      tok     <= '0;
      crc_ok  <= 1'b0;
      rx_data <= '0;
      rx_we   <= 1'b0;
    end else begin
      rx_we <= 1'b0;
      if (abort) begin
        crc_ok <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_wr || start_rd) begin
              crc_ok  <= 1'b1;
              blksize <= blksize_i;
              blk_cnt <= (blkcnt_i == 16'd0) ? 16'd1 : blkcnt_i;
            end
          end
          WR_START: begin
            shift   <= tx_data_i;
            bit_cnt <= '0;
            crc     <= '0;
          end
          WR_DATA: begin
            crc     <= crc_next;
            bit_cnt <= last_data_bit ? 15'd0 : bit_cnt + 15'd1;
            shift   <= (word_end && !last_data_bit) ? tx_data_i : {shift[30:0], 1'b0};
          end
          WR_CRC: begin
            crc     <= {crc[14:0], 1'b0};
            bit_cnt <= bit_cnt + 15'd1;
          end
          WR_END: gap_cnt <= '0;
          WR_GAP: begin
            gap_cnt <= gap_cnt + 3'd1;
            tok_cnt <= '0;
          end
          // tok_cnt 0 hunts for the start bit, 1..3 shift status, 4 is the end bit.
          WR_TOKEN: begin
            if (tok_cnt == 3'd0) begin
              if (!sd_dat_i) tok_cnt <= 3'd1;
            end else if (tok_cnt != 3'd4) begin
              tok     <= {tok[1:0], sd_dat_i};
              tok_cnt <= tok_cnt + 3'd1;
            end else if (tok != 3'b010) begin
              crc_ok <= 1'b0;
            end
          end
          WR_BUSY: if (sd_dat_i && !last_block) blk_cnt <= blk_cnt - 16'd1;
          RD_WAIT: begin
            bit_cnt <= '0;
            crc     <= '0;
          end
          RD_DATA: begin
            shift   <= {shift[30:0], sd_dat_i};
            crc     <= crc_next;
            bit_cnt <= last_data_bit ? 15'd0 : bit_cnt + 15'd1;
            if (word_end) begin
              rx_we   <= 1'b1;
              rx_data <= {shift[30:0], sd_dat_i};
            end
          end
          RD_CRC: begin
            if (sd_dat_i != crc[15]) crc_ok <= 1'b0;
            crc     <= {crc[14:0], 1'b0};
            bit_cnt <= bit_cnt + 15'd1;
          end
          RD_END: begin
            if (!sd_dat_i) crc_ok <= 1'b0;
            if (!last_block) blk_cnt <= blk_cnt - 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign xfr_complete_o = (state == IDLE);
  assign crc_ok_o       = crc_ok;
  assign rx_data_o      = rx_data;
  assign rx_we_o        = rx_we;

endmodule

// File: tb/tb_sd_data_serial_engine.sv
// Directed bench for sd_data_serial_engine: card-side models for DAT0 reads,
// write token/busy responses, plus tx/rx FIFO models.
module tb_sd_data_serial_engine;

  localparam int NWR = 2;

  logic        sd_clk = 1'b0;
  logic        rst;
  logic        start_write_i, start_read_i;
  logic [11:0] blksize_i;
  logic [15:0] blkcnt_i;
  logic [31:0] tx_data_i;
  logic        tx_rd_o;
  logic [31:0] rx_data_o;
  logic        rx_we_o;
  logic        sd_dat_i;
  logic        sd_dat_o, sd_dat_oe_o, xfr_complete_o, crc_ok_o;

  int compared   = 0;
  int mismatched = 0;

  sd_data_serial_engine #(.NWR(NWR)) dut (
    .sd_clk(sd_clk), .rst(rst),
    .start_write_i(start_write_i), .start_read_i(start_read_i),
    .blksize_i(blksize_i), .blkcnt_i(blkcnt_i),
    .tx_data_i(tx_data_i), .tx_rd_o(tx_rd_o),
    .rx_data_o(rx_data_o), .rx_we_o(rx_we_o),
    .sd_dat_i(sd_dat_i), .sd_dat_o(sd_dat_o), .sd_dat_oe_o(sd_dat_oe_o),
    .xfr_complete_o(xfr_complete_o), .crc_ok_o(crc_ok_o)
  );

  always #5 sd_clk = ~sd_clk;

  // First-word-fall-through tx FIFO model
  logic [31:0] tx_mem [0:7];
  int tx_pops  = 0;
  int tx_start = 0;
  assign tx_data_i = tx_mem[(tx_pops - tx_start) & 7];
  always @(posedge sd_clk) if (tx_rd_o) tx_pops <= tx_pops + 1;

  // rx FIFO monitor, comparing each push to the word the card sent
  logic [31:0] rd_mem [0:7];
  int rx_pushes = 0;
  int rx_bad    = 0;
  int rx_start  = 0;
  always @(posedge sd_clk) begin
    if (rx_we_o) begin
      if (rx_data_o !== rd_mem[(rx_pushes - rx_start) & 7]) rx_bad <= rx_bad + 1;
      rx_pushes <= rx_pushes + 1;
    end
  end

  // DAT0 capture while the engine drives the line
  logic line_bits [0:8191];
  int line_total = 0;
  int line_base  = 0;
  always @(posedge sd_clk) begin
    if (sd_dat_oe_o === 1'b1) begin
      line_bits[line_total & 8191] <= sd_dat_o;
      line_total <= line_total + 1;
    end
  end

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic [15:0] s;
    s = {c[14:0], 1'b0};
    return (c[15] ^ b) ? (s ^ 16'h1021) : s;
  endfunction

  function automatic logic [15:0] crc_of_mem(input bit use_tx, input int nwords);
    logic [15:0] c;
    logic [31:0] w;
    c = 16'h0000;
    for (int i = 0; i < nwords; i++) begin
      w = use_tx ? tx_mem[i & 7] : rd_mem[i & 7];
      for (int b = 31; b >= 0; b--) c = crc_step(c, w[b]);
    end
    return c;
  endfunction

  function automatic logic line_at(input int k);
    return line_bits[(line_base + k) & 8191];
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge sd_clk);
  endtask

  task automatic pulse(input logic w, input logic r);
    start_write_i = w;
    start_read_i  = r;
    @(negedge sd_clk);
    start_write_i = 1'b0;
    start_read_i  = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (xfr_complete_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge sd_clk);
    end
  endtask

  // Card answer to a written block: token start bit, 3 status bits, end bit, busy.
  task automatic card_token(input logic [2:0] status, input int busy, output bit ok);
    bit seen_hi, seen_lo;
    seen_hi = 1'b0;
    seen_lo = 1'b0;
    for (int i = 0; i < 40 && !seen_hi; i++) begin
      if (sd_dat_oe_o === 1'b1) seen_hi = 1'b1;
      else tick(1);
    end
    for (int i = 0; i < 20000 && seen_hi && !seen_lo; i++) begin
      if (sd_dat_oe_o === 1'b0) seen_lo = 1'b1;
      else tick(1);
    end
    ok = seen_hi & seen_lo;
    if (ok) begin
      sd_dat_i = 1'b1;
      tick(NWR + 1);
      sd_dat_i = 1'b0;
      tick(1);
      for (int k = 2; k >= 0; k--) begin
        sd_dat_i = status[k];
        tick(1);
      end
      sd_dat_i = 1'b1;
      tick(1);
      if (busy > 0) begin
        sd_dat_i = 1'b0;
        tick(busy);
      end
      sd_dat_i = 1'b1;
    end
  endtask

  task automatic card_block(input int nwords, input logic [15:0] crc, input logic endbit);
    logic [31:0] w;
    sd_dat_i = 1'b0;
    tick(1);
    for (int i = 0; i < nwords; i++) begin
      w = rd_mem[i & 7];
      for (int b = 31; b >= 0; b--) begin
        sd_dat_i = w[b];
        tick(1);
      end
    end
    for (int b = 15; b >= 0; b--) begin
      sd_dat_i = crc[b];
      tick(1);
    end
    sd_dat_i = endbit;
    tick(1);
    sd_dat_i = 1'b1;
    tick(2);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    compared++; if (xfr_complete_o !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_xfr: got %b want 1", xfr_complete_o); end
    compared++; if (crc_ok_o !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_crc_ok: got %b want 0", crc_ok_o); end
    compared++; if (sd_dat_oe_o !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_oe: got %b want 0", sd_dat_oe_o); end
    compared++; if (sd_dat_o !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_dat: got %b want 1", sd_dat_o); end
    compared++; if (tx_rd_o !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_tx_rd: got %b want 0", tx_rd_o); end
    compared++; if (rx_we_o !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_rx_we: got %b want 0", rx_we_o); end
    compared++; if (rx_data_o !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_rx_data: got %h want 0", rx_data_o); end
  endtask

  task automatic test_write_512;
    bit ok_tok, ok_idle;
    int ones, len;
    logic [15:0] got_crc;
    for (int i = 0; i < 8; i++) tx_mem[i] = 32'hFFFF_FFFF;
    blksize_i = 12'd512;
    blkcnt_i  = 16'd1;
    tx_start  = tx_pops;
    line_base = line_total;
    pulse(1'b1, 1'b0);
    compared++; if (xfr_complete_o !== 1'b0) begin mismatched++; $display("[TB] FAIL wr512_busy: got %b want 0", xfr_complete_o); end
    compared++; if (crc_ok_o !== 1'b1) begin mismatched++; $display("[TB] FAIL wr512_crc_ok_start: got %b want 1", crc_ok_o); end
    card_token(3'b010, 5, ok_tok);
    wait_idle(100, ok_idle);
    compared++; if (!(ok_tok && ok_idle)) begin mismatched++; $display("[TB] FAIL wr512_timeout: token %b idle %b want 1 1", ok_tok, ok_idle); end
    len = line_total - line_base;
    compared++; if (len !== 4115) begin mismatched++; $display("[TB] FAIL wr512_line_len: got %0d want 4115", len); end
    compared++; if ({line_at(0), line_at(1)} !== 2'b10) begin mismatched++; $display("[TB] FAIL wr512_preamble: got %b%b want 10", line_at(0), line_at(1)); end
    ones = 0;
    for (int k = 2; k < 4098; k++) if (line_at(k) === 1'b1) ones++;
    compared++; if (ones !== 4096) begin mismatched++; $display("[TB] FAIL wr512_data_ones: got %0d want 4096", ones); end
    got_crc = '0;
    for (int k = 0; k < 16; k++) got_crc = {got_crc[14:0], line_at(4098 + k)};
    compared++; if (got_crc !== 16'h7FA1) begin mismatched++; $display("[TB] FAIL wr512_crc: got %h want 7fa1", got_crc); end
    compared++; if (line_at(4114) !== 1'b1) begin mismatched++; $display("[TB] FAIL wr512_end_bit: got %b want 1", line_at(4114)); end
    compared++; if (tx_pops - tx_start !== 128) begin mismatched++; $display("[TB] FAIL wr512_pops: got %0d want 128", tx_pops - tx_start); end
    compared++; if (xfr_complete_o !== 1'b1) begin mismatched++; $display("[TB] FAIL wr512_done: got %b want 1", xfr_complete_o); end
    compared++; if (crc_ok_o !== 1'b1) begin mismatched++; $display("[TB] FAIL wr512_crc_ok: got %b want 1", crc_ok_o); end
  endtask

  task automatic test_read_two_blocks;
    bit ok_idle;
    int p0, b0;
    for (int i = 0; i < 8; i++) rd_mem[i] = 32'hFFFF_FFFF;
    blksize_i = 12'd512;
    blkcnt_i  = 16'd2;
    rx_start  = rx_pushes;
    p0 = rx_pushes;
    b0 = rx_bad;
    pulse(1'b0, 1'b1);
    card_block(128, 16'h7FA1, 1'b1);
    card_block(128, 16'h7FA1, 1'b1);
    wait_idle(20, ok_idle);
    compared++; if (!ok_idle) begin mismatched++; $display("[TB] FAIL rd2_timeout: idle %b want 1", ok_idle); end
    compared++; if (rx_pushes - p0 !== 256) begin mismatched++; $display("[TB] FAIL rd2_pushes: got %0d want 256", rx_pushes - p0); end
    compared++; if (rx_bad - b0 !== 0) begin mismatched++; $display("[TB] FAIL rd2_data: got %0d bad words want 0", rx_bad - b0); end
    compared++; if (crc_ok_o !== 1'b1) begin mismatched++; $display("[TB] FAIL rd2_crc_ok: got %b want 1", crc_ok_o); end
  endtask

  task automatic test_read_bad_crc;
    bit ok_idle;
    int p0;
    blksize_i = 12'd512;
    blkcnt_i  = 16'd1;
    rx_start  = rx_pushes;
    p0 = rx_pushes;
    pulse(1'b0, 1'b1);
    card_block(128, 16'h7FA0, 1'b1);
    wait_idle(10, ok_idle);
    compared++; if (!ok_idle) begin mismatched++; $display("[TB] FAIL rdbad_timeout: idle %b want 1", ok_idle); end
    compared++; if (rx_pushes - p0 !== 128) begin mismatched++; $display("[TB] FAIL rdbad_pushes: got %0d want 128", rx_pushes - p0); end
    compared++; if (crc_ok_o !== 1'b0) begin mismatched++; $display("[TB] FAIL rdbad_crc_ok: got %b want 0", crc_ok_o); end
  endtask

  task automatic test_read_small;
    bit ok_idle;
    int p0, b0;
    rd_mem[0] = 32'h1234_5678;
    rd_mem[1] = 32'h9ABC_DEF0;
    blksize_i = 12'd8;
    blkcnt_i  = 16'd0;
    rx_start  = rx_pushes;
    p0 = rx_pushes;
    b0 = rx_bad;
    pulse(1'b0, 1'b1);
    card_block(2, crc_of_mem(1'b0, 2), 1'b1);
    wait_idle(10, ok_idle);
    compared++; if (!ok_idle) begin mismatched++; $display("[TB] FAIL rd8_single_block: idle %b want 1", ok_idle); end
    compared++; if (rx_pushes - p0 !== 2) begin mismatched++; $display("[TB] FAIL rd8_pushes: got %0d want 2", rx_pushes - p0); end
    compared++; if (rx_bad - b0 !== 0) begin mismatched++; $display("[TB] FAIL rd8_data: got %0d bad words want 0", rx_bad - b0); end
    compared++; if (crc_ok_o !== 1'b1) begin mismatched++; $display("[TB] FAIL rd8_crc_ok: got %b want 1", crc_ok_o); end
    rd_mem[0] = 32'hC001_D00D;
    blksize_i = 12'd4;
    blkcnt_i  = 16'd1;
    rx_start  = rx_pushes;
    pulse(1'b0, 1'b1);
    card_block(1, crc_of_mem(1'b0, 1), 1'b0);
    wait_idle(10, ok_idle);
    compared++; if (rx_data_o !== 32'hC001_D00D) begin mismatched++; $display("[TB] FAIL rd4_word: got %h want c001d00d", rx_data_o); end
    compared++; if (crc_ok_o !== 1'b0) begin mismatched++; $display("[TB] FAIL rd4_end_bit_crc_ok: got %b want 0", crc_ok_o); end
  endtask

  task automatic test_write_bad_token;
    bit ok_tok;
    for (int i = 0; i < 8; i++) tx_mem[i] = 32'hFFFF_FFFF;
    blksize_i = 12'd512;
    blkcnt_i  = 16'd2;
    tx_start  = tx_pops;
    pulse(1'b1, 1'b0);
    card_token(3'b101, 0, ok_tok);
    tick(30);
    compared++; if (!ok_tok) begin mismatched++; $display("[TB] FAIL wrtok_timeout: token %b want 1", ok_tok); end
    compared++; if (tx_pops - tx_start !== 128) begin mismatched++; $display("[TB] FAIL wrtok_pops: got %0d want 128", tx_pops - tx_start); end
    compared++; if (xfr_complete_o !== 1'b1) begin mismatched++; $display("[TB] FAIL wrtok_idle: got %b want 1", xfr_complete_o); end
    compared++; if (crc_ok_o !== 1'b0) begin mismatched++; $display("[TB] FAIL wrtok_crc_ok: got %b want 0", crc_ok_o); end
    compared++; if (sd_dat_oe_o !== 1'b0) begin mismatched++; $display("[TB] FAIL wrtok_oe: got %b want 0", sd_dat_oe_o); end
  endtask

  task automatic test_abort_read;
    int p0;
    blksize_i = 12'd512;
    blkcnt_i  = 16'd1;
    p0 = rx_pushes;
    sd_dat_i = 1'b1;
    pulse(1'b0, 1'b1);
    tick(3);
    pulse(1'b1, 1'b0);
    tick(2);
    compared++; if (sd_dat_oe_o !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_ignored_start_oe: got %b want 0", sd_dat_oe_o); end
    tick(44);
    compared++; if (xfr_complete_o !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_still_busy: got %b want 0", xfr_complete_o); end
    compared++; if (crc_ok_o !== 1'b1) begin mismatched++; $display("[TB] FAIL abort_crc_ok_before: got %b want 1", crc_ok_o); end
    pulse(1'b1, 1'b1);
    compared++; if (xfr_complete_o !== 1'b1) begin mismatched++; $display("[TB] FAIL abort_xfr: got %b want 1", xfr_complete_o); end
    compared++; if (crc_ok_o !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_crc_ok: got %b want 0", crc_ok_o); end
    compared++; if ({sd_dat_oe_o, sd_dat_o} !== 2'b01) begin mismatched++; $display("[TB] FAIL abort_line: got oe %b dat %b want 0 1", sd_dat_oe_o, sd_dat_o); end
    tick(5);
    compared++; if (rx_pushes - p0 !== 0) begin mismatched++; $display("[TB] FAIL abort_rx_we: got %0d pushes want 0", rx_pushes - p0); end
  endtask

  task automatic test_reset_mid_write;
    for (int i = 0; i < 8; i++) tx_mem[i] = 32'hFFFF_FFFF;
    blksize_i = 12'd512;
    blkcnt_i  = 16'd1;
    tx_start  = tx_pops;
    pulse(1'b1, 1'b0);
    tick(100);
    compared++; if (sd_dat_oe_o !== 1'b1) begin mismatched++; $display("[TB] FAIL rstmid_driving: got %b want 1", sd_dat_oe_o); end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    compared++; if (xfr_complete_o !== 1'b1) begin mismatched++; $display("[TB] FAIL rstmid_xfr: got %b want 1", xfr_complete_o); end
    compared++; if (crc_ok_o !== 1'b0) begin mismatched++; $display("[TB] FAIL rstmid_crc_ok: got %b want 0", crc_ok_o); end
    compared++; if ({sd_dat_oe_o, sd_dat_o} !== 2'b01) begin mismatched++; $display("[TB] FAIL rstmid_line: got oe %b dat %b want 0 1", sd_dat_oe_o, sd_dat_o); end
    compared++; if ({tx_rd_o, rx_we_o} !== 2'b00) begin mismatched++; $display("[TB] FAIL rstmid_strobes: got %b%b want 00", tx_rd_o, rx_we_o); end
    compared++; if (rx_data_o !== 32'h0) begin mismatched++; $display("[TB] FAIL rstmid_rx_data: got %h want 0", rx_data_o); end
  endtask

  task automatic test_write_small;
    bit ok_tok, ok_idle;
    logic [31:0] got_word;
    logic [15:0] got_crc;
    tx_mem[0] = 32'hA5C3_0F12;
    blksize_i = 12'd4;
    blkcnt_i  = 16'd1;
    tx_start  = tx_pops;
    line_base = line_total;
    pulse(1'b1, 1'b0);
    card_token(3'b010, 3, ok_tok);
    wait_idle(50, ok_idle);
    compared++; if (!(ok_tok && ok_idle)) begin mismatched++; $display("[TB] FAIL wr4_timeout: token %b idle %b want 1 1", ok_tok, ok_idle); end
    compared++; if (line_total - line_base !== 51) begin mismatched++; $display("[TB] FAIL wr4_line_len: got %0d want 51", line_total - line_base); end
    got_word = '0;
    for (int k = 0; k < 32; k++) got_word = {got_word[30:0], line_at(2 + k)};
    compared++; if (got_word !== 32'hA5C3_0F12) begin mismatched++; $display("[TB] FAIL wr4_data: got %h want a5c30f12", got_word); end
    got_crc = '0;
    for (int k = 0; k < 16; k++) got_crc = {got_crc[14:0], line_at(34 + k)};
    compared++; if (got_crc !== crc_of_mem(1'b1, 1)) begin mismatched++; $display("[TB] FAIL wr4_crc: got %h want %h", got_crc, crc_of_mem(1'b1, 1)); end
    compared++; if (tx_pops - tx_start !== 1) begin mismatched++; $display("[TB] FAIL wr4_pops: got %0d want 1", tx_pops - tx_start); end
    compared++; if (crc_ok_o !== 1'b1) begin mismatched++; $display("[TB] FAIL wr4_crc_ok: got %b want 1", crc_ok_o); end
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst           = 1'b1;
    start_write_i = 1'b0;
    start_read_i  = 1'b0;
    blksize_i     = 12'd4;
    blkcnt_i      = 16'd1;
    sd_dat_i      = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tx_mem[i] = 32'hFFFF_FFFF;
      rd_mem[i] = 32'hFFFF_FFFF;
    end
    @(negedge sd_clk);
    test_reset();
    test_write_512();
    test_read_two_blocks();
    test_read_bad_crc();
    test_read_small();
    test_write_bad_token();
    test_abort_read();
    test_reset_mid_write();
    test_write_small();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
